fnd_scan_decoder: RTL and testbench

//  Receive-side counterpart of the FND display controller. Samples the multiplexed 4-digit
//  7-seg scan bus (fnd_digit/fnd_data, both active-low), debounces each scan step and decodes

---
 rtl/fnd_pkg.sv | 63 ++++++
 rtl/fnd_scan_decoder_seg_decode.sv | 31 +++
 rtl/fnd_scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan-bus decoder.
// Segment codes are active-low with bit7 = dp.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DOT   = 8'h7F;

    // Decode class of one sampled segment code
    typedef enum logic [1:0] {
        ClsNum,
        ClsBlank,
        ClsDot,
        ClsErr
    } seg_class_t;

    // Capture FSM state encoding
    typedef logic [1:0] cap_state_t;
    localparam cap_state_t StIdle   = 2'd0;
    localparam cap_state_t StSettle = 2'd1;
    localparam cap_state_t StHeld   = 2'd2;

    // True when exactly one strobe line is low
    function automatic logic strobe_valid(input logic [3:0] dig);
        logic ok;
        case (dig)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Position index of the low strobe line (only meaningful when strobe_valid)
    function automatic logic [1:0] strobe_pos(input logic [3:0] dig);
        logic [1:0] p;
        case (dig)
            4'b1101: p = 2'd1;
            4'b1011: p = 2'd2;
            4'b0111: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // tens*10 + ones, using shifts; result is at most 99 for valid BCD
    function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t;
        logic [6:0] o;
        t = {3'b000, tens};
        o = {3'b000, ones};
        return (t << 3) + (t << 1) + o;
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_seg_decode.sv
// Combinational segment-code classifier: 8-bit active-low code -> class + BCD value.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [7:0]  code,
    output seg_class_t  cls,
    output logic [3:0]  bcd
);

    // Map each recognised code to its numeral, blank or dot class
    always_comb begin
        cls = ClsNum;
        bcd = 4'd0;
        case (code)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: cls = ClsBlank;
            SEG_DOT:   cls = ClsDot;
            default:   cls = ClsErr;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low 7-seg scan bus.
// Debounces each scan step, decodes digits/dots and reports completed frames.
// Optional macro FND_SCAN_SYNC_EN adds a 2-flop input synchronizer (+2 clocks latency).
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_digit,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digit_val,
    output logic [3:0]  dot_val,
    output logic [6:0]  lo_val,
    output logic [6:0]  hi_val,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        scan_lost
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [ToW-1:0]  ToMax      = ToW'(TIMEOUT_CYCLES);

    logic [11:0] bus;

`ifdef FND_SCAN_SYNC_EN
    logic [11:0] sync1_q;
    logic [11:0] sync2_q;

    // Two-stage synchronizer; reset to the idle (all-off) bus pattern
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 12'hFFF;
            sync2_q <= 12'hFFF;
        end else begin
            sync1_q <= {fnd_digit, fnd_data};
            sync2_q <= sync1_q;
        end
    end
    assign bus = sync2_q;
`else
    assign bus = {fnd_digit, fnd_data};
`endif

    logic [3:0]  bus_dig;
    logic [7:0]  bus_seg;
    logic [1:0]  pos;
    logic        strobe_ok;
    seg_class_t  cls;
    logic [3:0]  bcd;

    assign bus_dig   = bus[11:8];
    assign bus_seg   = bus[7:0];
    assign strobe_ok = strobe_valid(bus_dig);
    assign pos       = strobe_pos(bus_dig);

    fnd_seg_decode u_seg_decode (
        .code (bus_seg),
        .cls  (cls),
        .bcd  (bcd)
    );

    logic [11:0]      prev_q, prev_d;
    cap_state_t       st_q, st_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [3:0][3:0]  staging_q, staging_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      digit_q, digit_d;
    logic [3:0]       dot_q, dot_d;
    logic [6:0]       lo_q, lo_d;
    logic [6:0]       hi_q, hi_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             capture;

    // Next-state: debounce FSM, capture decode, frame assembly and timeout
    always_comb begin
        prev_d    = bus;
        st_d      = st_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        staging_d = staging_q;
        seen_d    = seen_q;
        digit_d   = digit_q;
        dot_d     = dot_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        fv_d      = 1'b0;
        err_d     = 1'b0;
        lost_d    = lost_q;
        capture   = 1'b0;

        if (bus != prev_q) begin
            if (strobe_ok) begin
                st_d  = StSettle;
                cnt_d = CntW'(1);
                if (STABLE_CYCLES == 1) begin
                    capture = 1'b1;
                end
            end else begin
                st_d  = StIdle;
                cnt_d = '0;
            end
        end else if (st_q == StSettle) begin
            if (cnt_q == StableLast) begin
                capture = 1'b1;
            end
            cnt_d = cnt_q + 1'b1;
        end

        if (capture) begin
            st_d = StHeld;
            unique case (cls)
                ClsNum: begin
                    staging_d[pos] = bcd;
                    seen_d[pos]    = 1'b1;
                    if (pos == 2'd3) begin
                        // Frame closes on pos3; publish only if pos0..pos2 were all seen
                        if (seen_q[2:0] == 3'b111) begin
                            digit_d = {bcd, staging_q[2], staging_q[1], staging_q[0]};
                            lo_d    = bcd_pair(staging_q[1], staging_q[0]);
                            hi_d    = bcd_pair(bcd, staging_q[2]);
                            fv_d    = 1'b1;
                        end
                        seen_d = '0;
                    end
                end
                ClsBlank, ClsDot: begin
                    dot_d[pos] = (cls == ClsDot);
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end

        // Unrecognised codes leave the timeout untouched
        if (capture && (cls != ClsErr)) begin
            to_d   = '0;
            lost_d = 1'b0;
        end else if (to_q != ToMax) begin
            to_d = to_q + 1'b1;
            if (to_d == ToMax) begin
                lost_d = 1'b1;
                seen_d = '0;
            end
        end
    end

    // State registers; bus history resets to the idle pattern
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= 12'hFFF;
            st_q      <= StIdle;
            cnt_q     <= '0;
            to_q      <= '0;
            staging_q <= '0;
            seen_q    <= '0;
            digit_q   <= '0;
            dot_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            prev_q    <= prev_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            staging_q <= staging_d;
            seen_q    <= seen_d;
            digit_q   <= digit_d;
            dot_q     <= dot_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
        end
    end

    assign digit_val   = digit_q;
    assign dot_val     = dot_q;
    assign lo_val      = lo_q;
    assign hi_val      = hi_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;
    assign scan_lost   = lost_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed self-checking bench for fnd_scan_decoder (short timeout for simulation speed).
module tb_fnd_scan_decoder;

    localparam int TO = 300;
`ifdef FND_SCAN_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    localparam logic [3:0] P0 = 4'b1110;
    localparam logic [3:0] P1 = 4'b1101;
    localparam logic [3:0] P2 = 4'b1011;
    localparam logic [3:0] P3 = 4'b0111;
    localparam logic [3:0] PN = 4'b1111;

    logic        clk;
    logic        reset;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;
    logic [15:0] digit_val;
    logic [3:0]  dot_val;
    logic [6:0]  lo_val;
    logic [6:0]  hi_val;
    logic        frame_valid;
    logic        seg_err;
    logic        scan_lost;

    int total;
    int bad;
    int fv_cnt;
    int err_cnt;
    int fv_at;
    int err_at;
    int clr_at;

    fnd_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fnd_digit   (fnd_digit),
        .fnd_data    (fnd_data),
        .digit_val   (digit_val),
        .dot_val     (dot_val),
        .lo_val      (lo_val),
        .hi_val      (hi_val),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .scan_lost   (scan_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus value for n clocks, sampling on falling edges
    task automatic drive_step(input logic [3:0] dig, input logic [7:0] dat, input int n);
        fnd_digit = dig;
        fnd_data  = dat;
        fv_at  = 0;
        err_at = 0;
        clr_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                fv_cnt++;
                fv_at = i;
            end
            if (seg_err) begin
                err_cnt++;
                err_at = i;
            end
            if (!scan_lost && clr_at == 0) clr_at = i;
        end
    endtask

    task automatic scan_1234();
        drive_step(P0, 8'h99, 10);
        drive_step(P1, 8'hB0, 10);
        drive_step(P2, 8'hA4, 10);
        drive_step(P3, 8'hF9, 10);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fnd_digit = 4'($urandom);
            fnd_data  = 8'($urandom);
            @(negedge clk);
        end
        total++; if (digit_val !== 16'h0) begin bad++;
            $display("FAIL reset_digit: got %h want 0000", digit_val); end
        total++; if (dot_val !== 4'h0) begin bad++;
            $display("FAIL reset_dot: got %b want 0000", dot_val); end
        total++; if (lo_val !== 7'd0 || hi_val !== 7'd0) begin bad++;
            $display("FAIL reset_lohi: got %0d/%0d want 0/0", lo_val, hi_val); end
        total++; if (frame_valid !== 1'b0 || seg_err !== 1'b0) begin bad++;
            $display("FAIL reset_pulses: got fv=%b err=%b want 0/0", frame_valid, seg_err); end
        total++; if (scan_lost !== 1'b1) begin bad++;
            $display("FAIL reset_lost: got %b want 1", scan_lost); end
        fnd_digit = PN;
        fnd_data  = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        fv_cnt  = 0;
        err_cnt = 0;
        drive_step(PN, 8'hFF, 20);
        total++; if (fv_cnt != 0 || err_cnt != 0) begin bad++;
            $display("FAIL release_pulses: got fv=%0d err=%0d want 0/0", fv_cnt, err_cnt); end
    endtask

    task automatic test_scan();
        drive_step(PN, 8'hFF, 5);
        fv_cnt = 0;
        scan_1234();
        total++; if (fv_cnt != 1) begin bad++;
            $display("FAIL scan_fv_count: got %0d want 1", fv_cnt); end
        total++; if (fv_at != LAT) begin bad++;
            $display("FAIL scan_fv_latency: got %0d want %0d", fv_at, LAT); end
        total++; if (digit_val !== 16'h1234) begin bad++;
            $display("FAIL scan_digit: got %h want 1234", digit_val); end
        total++; if (lo_val !== 7'd34 || hi_val !== 7'd12) begin bad++;
            $display("FAIL scan_lohi: got %0d/%0d want 34/12", lo_val, hi_val); end
        total++; if (scan_lost !== 1'b0 || dot_val !== 4'h0) begin bad++;
            $display("FAIL scan_lost_dot: got %b/%b want 0/0000", scan_lost, dot_val); end
    endtask

    task automatic test_dot();
        fv_cnt = 0;
        drive_step(P2, 8'h7F, 10);
        total++; if (dot_val !== 4'b0100) begin bad++;
            $display("FAIL dot_on: got %b want 0100", dot_val); end
        drive_step(P2, 8'hFF, 10);
        total++; if (dot_val !== 4'b0000) begin bad++;
            $display("FAIL dot_off: got %b want 0000", dot_val); end
        total++; if (digit_val !== 16'h1234 || fv_cnt != 0) begin bad++;
            $display("FAIL dot_digit: got %h fv=%0d want 1234 fv=0", digit_val, fv_cnt); end
    endtask

    task automatic test_glitch();
        fv_cnt = 0;
        drive_step(P0, 8'h92, 10);
        drive_step(P1, 8'hB0, 10);
        drive_step(P1, 8'hFF, 10);
        drive_step(P1, 8'hC0, 3);
        drive_step(P1, 8'hFF, 10);
        drive_step(P2, 8'hF8, 10);
        drive_step(P3, 8'hF9, 10);
        total++; if (digit_val !== 16'h1735 || lo_val !== 7'd35 || hi_val !== 7'd17) begin bad++;
            $display("FAIL glitch_reject: got %h %0d/%0d want 1735 35/17",
                     digit_val, lo_val, hi_val); end
        drive_step(P0, 8'h92, 10);
        drive_step(P1, 8'hC0, 10);
        drive_step(P2, 8'hF8, 10);
        drive_step(P3, 8'hF9, 10);
        total++; if (digit_val !== 16'h1705 || lo_val !== 7'd5 || hi_val !== 7'd17) begin bad++;
            $display("FAIL glitch_held: got %h %0d/%0d want 1705 5/17",
                     digit_val, lo_val, hi_val); end
        total++; if (fv_cnt != 2) begin bad++;
            $display("FAIL glitch_fv_count: got %0d want 2", fv_cnt); end
    endtask

    task automatic test_seg_err();
        fv_cnt  = 0;
        err_cnt = 0;
        drive_step(P0, 8'h80, 10);
        drive_step(P1, 8'h00, 10);
        total++; if (err_cnt != 1 || err_at != LAT) begin bad++;
            $display("FAIL seg_err_pulse: got count=%0d at=%0d want 1 at %0d",
                     err_cnt, err_at, LAT); end
        drive_step(P2, 8'h90, 10);
        drive_step(P3, 8'h82, 10);
        total++; if (fv_cnt != 0 || digit_val !== 16'h1705) begin bad++;
            $display("FAIL seg_err_noframe: got fv=%0d digit=%h want 0 1705", fv_cnt, digit_val); end
        drive_step(P0, 8'h80, 10);
        drive_step(P1, 8'hC0, 10);
        drive_step(P2, 8'h90, 10);
        drive_step(P3, 8'h82, 10);
        total++; if (fv_cnt != 1 || digit_val !== 16'h6908) begin bad++;
            $display("FAIL seg_err_recover: got fv=%0d digit=%h want 1 6908", fv_cnt, digit_val); end
        total++; if (lo_val !== 7'd8 || hi_val !== 7'd69) begin bad++;
            $display("FAIL seg_err_lohi: got %0d/%0d want 8/69", lo_val, hi_val); end
    endtask

    task automatic test_reset_mid();
        fv_cnt = 0;
        drive_step(P0, 8'h99, 10);
        drive_step(P1, 8'hB0, 10);
        drive_step(P2, 8'hA4, 10);
        reset = 1'b0;
        @(negedge clk);
        total++; if (digit_val !== 16'h0 || scan_lost !== 1'b1) begin bad++;
            $display("FAIL mid_reset_clear: got %h lost=%b want 0000 1", digit_val, scan_lost); end
        reset = 1'b1;
        drive_step(P3, 8'hF9, 10);
        total++; if (fv_cnt != 0 || digit_val !== 16'h0) begin bad++;
            $display("FAIL mid_reset_partial: got fv=%0d digit=%h want 0 0000", fv_cnt, digit_val); end
        scan_1234();
        total++; if (fv_cnt != 1 || digit_val !== 16'h1234) begin bad++;
            $display("FAIL mid_reset_full: got fv=%0d digit=%h want 1 1234", fv_cnt, digit_val); end
    endtask

    task automatic test_timeout();
        int found;
        fv_cnt = 0;
        drive_step(P0, 8'h99, 10);
        drive_step(P1, 8'hB0, 10);
        drive_step(P2, 8'hA4, 10);
        fnd_digit = PN;
        fnd_data  = 8'hFF;
        found = 0;
        for (int j = 1; j <= TO + 50; j++) begin
            @(negedge clk);
            if (scan_lost) begin
                found = j;
                break;
            end
        end
        total++; if (found != TO - 10 + LAT) begin bad++;
            $display("FAIL timeout_edge: got %0d want %0d", found, TO - 10 + LAT); end
        drive_step(P3, 8'hF9, 10);
        total++; if (clr_at != LAT) begin bad++;
            $display("FAIL timeout_clear: got %0d want %0d", clr_at, LAT); end
        total++; if (fv_cnt != 0 || digit_val !== 16'h1234) begin bad++;
            $display("FAIL timeout_seen_cleared: got fv=%0d digit=%h want 0 1234",
                     fv_cnt, digit_val); end
        scan_1234();
        total++; if (fv_cnt != 1 || fv_at != LAT || scan_lost !== 1'b0) begin bad++;
            $display("FAIL timeout_rescan: got fv=%0d at=%0d lost=%b want 1 %0d 0",
                     fv_cnt, fv_at, scan_lost, LAT); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        fv_cnt    = 0;
        err_cnt   = 0;
        fnd_digit = PN;
        fnd_data  = 8'hFF;
        reset     = 1'b0;
        test_reset();
        test_scan();
        test_dot();
        test_glitch();
        test_seg_err();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
